eth_rx_frame_ctrl: RTL and testbench
====================================

// Module: eth_rx_frame_ctrl
// PURPOSE
//  Frame sequencer for the clk_125m side of the PHY RX CDC FIFO. Consumes the byte stream rx_dat/rx_dv.
//  Hunts preamble/SFD, filters on destination MAC, checks length and FCS, strips the FCS.
//  Emits framed bytes (sof/eof/err) to the UDP/GPSDO parser and keeps drop/error statistics.
// PARAMETERS
//  MAX_LEN   1518  max frame bytes after SFD incl. FCS; longer frames are truncated with err
//  MIN_LEN   64    min frame bytes after SFD incl. FCS; shorter frames end with err
//  IFG_TMO   4     consecutive rx_dv-low cycles that terminate a frame (absorbs FIFO rate gaps)
// PORTS
//  clk_125m   in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  rx_dat     in   8   byte from CDC FIFO
//  rx_dv      in   1   rx_dat valid
//  mac_addr   in   48  own MAC; [47:40] is the first byte on the wire
//  promisc    in   1   1 = accept every destination MAC
//  out_dat    out  8   frame byte (DA onward, FCS removed)
//  out_vd     out  1   out_dat valid
//  out_sof    out  1   first byte of frame, qualified by out_vd
//  out_eof    out  1   last byte of frame, qualified by out_vd
//  out_err    out  1   frame bad (CRC, runt or oversize), valid only with out_eof
//  cnt_ok     out  16  good frames delivered, saturating
//  cnt_crc    out  16  frames with bad FCS, saturating
//  cnt_filt   out  16  frames dropped by MAC filter or bad preamble, saturating
// BEHAVIOUR
//  Reset: all outputs and counters 0. State is IDLE, delay line is cleared and CRC = 32'hFFFFFFFF.
//  gap counter: counts rx_dv-low cycles and clears on rx_dv=1. "end" = gap reaches IFG_TMO while in HDR/PASS/DROP.
//  States:
//   IDLE:  rx_dv&&0x55 -> PRE; other valid byte -> DROP.
//   PRE:   0x55 -> stay; 0xD5 -> HDR (len=0, CRC init); other -> DROP, cnt_filt++; end -> IDLE.
//   HDR:   each byte shifts into 6-stage delay line, CRC updated, len++. At len==6 compare DA with
//          mac_addr, 48'hFFFF_FFFF_FFFF or promisc: match -> PASS, miss -> DROP with cnt_filt++.
//          end with len<6 -> IDLE silently, counted in no counter.
//   PASS:  each valid byte shifts in and the oldest byte is emitted (out_vd=1). The first emission
//          carries out_sof. len++ per byte.
//          len reaching MAX_LEN+1 -> emit the shifted-out byte with out_eof=out_err=1 -> DROP.
//          end -> FLUSH.
//   FLUSH: 2 cycles; emits delay stages 5 then 4 (oldest first). Stages 3..0 hold the FCS and are
//          discarded. The second byte carries out_eof; out_sof is set on the first if nothing was
//          emitted yet. out_err = (CRC != 32'hDEBB20E3) | (len < MIN_LEN). cnt_ok or cnt_crc ++
//          (runt with good CRC counts neither). -> IDLE. rx_dv bytes arriving in FLUSH are ignored.
//   DROP:  ignore bytes until end -> IDLE.
//  Bytes emitted per accepted frame = len-4; output lags input by exactly 6 accepted bytes.
//  CRC: reflected poly 32'hEDB88320, LSB first, one byte per cycle over all bytes after SFD incl. FCS.
//  Counters hold at 16'hFFFF.
//  out_vd/out_sof/out_eof/out_err are registered 1-cycle pulses; out_sof/out_eof/out_err are 0 when out_vd=0.
//  rst_n low mid-frame: immediate return to reset values; no eof is emitted for the aborted frame.
// TESTING
//  1. 7x55,D5, 64-byte frame, DA=mac_addr, valid FCS -> 60 out bytes, sof on 1st, eof on 60th, err=0, cnt_ok=1.
//  2. Same frame with one payload bit flipped -> 60 bytes, eof with err=1, cnt_crc=1, cnt_ok unchanged.
//  3. DA=02:00:00:00:00:99 != mac_addr, promisc=0 -> no out_vd, cnt_filt=1. Repeat with promisc=1 -> delivered.
//  4. 1600-byte broadcast frame, MAX_LEN=1518 -> 1513 bytes out, eof+err on the 1513th, then nothing until gap.
//  5. rx_dv gaps of 3 cycles inside a frame, IFG_TMO=4 -> frame delivered intact. Gap of 4 -> frame ends there.
//  6. Two back-to-back frames separated by IFG_TMO+2 idle cycles -> both delivered, cnt_ok=2.
//     rst_n pulsed mid-frame -> outputs 0 and the next frame is received correctly.

Source files
------------

// File: rtl/eth_rx_frame_ctrl_if.sv
// Byte-stream bundle around the RX frame sequencer.
//   rx_dat/rx_dv                       : byte stream from the PHY RX CDC FIFO
//   out_dat/out_vd/out_sof/out_eof/out_err : framed bytes towards the UDP/GPSDO parser
// master = side that feeds rx bytes and consumes framed bytes; slave = the sequencer.
interface eth_rx_frame_ctrl_if;
  logic [7:0] rx_dat;
  logic       rx_dv;
  logic [7:0] out_dat;
  logic       out_vd;
  logic       out_sof;
  logic       out_eof;
  logic       out_err;

  modport master (
    output rx_dat, rx_dv,
    input  out_dat, out_vd, out_sof, out_eof, out_err
  );

  modport slave (
    input  rx_dat, rx_dv,
    output out_dat, out_vd, out_sof, out_eof, out_err
  );
endinterface

// File: rtl/eth_rx_frame_ctrl.sv
// Ethernet RX frame sequencer on the clk_125m side of the PHY RX CDC FIFO.
// Hunts preamble/SFD, filters on destination MAC, checks length and FCS, strips the FCS and
// emits framed bytes with sof/eof/err. Keeps saturating good/CRC/filter statistics.
// Ports:
//   clk_125m, rst_n   : system clock, asynchronous active-low reset
//   bus (slave)       : rx_dat/rx_dv in, out_dat/out_vd/out_sof/out_eof/out_err out
//   mac_addr          : own MAC, [47:40] is the first byte on the wire
//   promisc           : accept every destination MAC
//   cnt_ok/crc/filt   : good frames, bad-FCS frames, filtered/bad-preamble frames (saturating)
module eth_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned IFG_TMO = 4
) (
  input  logic                      clk_125m,
  input  logic                      rst_n,
  eth_rx_frame_ctrl_if.slave        bus,
  input  logic [47:0]               mac_addr,
  input  logic                      promisc,
  output logic [15:0]               cnt_ok,
  output logic [15:0]               cnt_crc,
  output logic [15:0]               cnt_filt
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 2);
  localparam int unsigned GapW = $clog2(IFG_TMO + 1);
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPre   = 3'd1;
  localparam logic [2:0] StHdr   = 3'd2;
  localparam logic [2:0] StPass  = 3'd3;
  localparam logic [2:0] StFlush = 3'd4;
  localparam logic [2:0] StDrop  = 3'd5;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] dat);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ dat[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [5:0][7:0]  dly_q, dly_d;       // stage 5 is the oldest byte
  logic [31:0]      crc_q, crc_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             sof_pend_q, sof_pend_d;  // no byte of the current frame emitted yet
  logic             flush_q, flush_d;        // second FLUSH cycle
  logic [7:0]       out_dat_q, out_dat_d;
  logic             out_vd_q, out_vd_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [15:0]      cnt_ok_q, cnt_crc_q, cnt_filt_q;
  logic             inc_ok, inc_crc, inc_filt;

  logic             frame_end;
  logic [47:0]      da;
  logic             da_ok;
  logic             crc_bad;
  logic             runt;

  // End of frame fires on the IFG_TMO-th consecutive idle cycle.
  assign frame_end = !bus.rx_dv && (gap_q >= GapW'(IFG_TMO - 1));
  assign gap_d     = bus.rx_dv ? '0 :
                     (gap_q == GapW'(IFG_TMO)) ? gap_q : gap_q + GapW'(1);

  // DA is complete on the arrival of the 6th header byte.
  assign da      = {dly_q[4:0], bus.rx_dat};
  assign da_ok   = promisc || (da == mac_addr) || (da == 48'hFFFF_FFFF_FFFF);
  assign crc_bad = (crc_q != CrcResidue);
  assign runt    = (len_q < LenW'(MIN_LEN));

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    crc_d      = crc_q;
    len_d      = len_q;
    sof_pend_d = sof_pend_q;
    flush_d    = flush_q;
    out_dat_d  = 8'h00;
    out_vd_d   = 1'b0;
    out_sof_d  = 1'b0;
    out_eof_d  = 1'b0;
    out_err_d  = 1'b0;
    inc_ok     = 1'b0;
    inc_crc    = 1'b0;
    inc_filt   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.rx_dv) state_d = (bus.rx_dat == 8'h55) ? StPre : StDrop;
      end
      StPre: begin
        if (bus.rx_dv) begin
          if (bus.rx_dat == 8'hD5) begin
            state_d = StHdr;
            len_d   = '0;
            crc_d   = 32'hFFFF_FFFF;
          end else if (bus.rx_dat != 8'h55) begin
            state_d  = StDrop;
            inc_filt = 1'b1;
          end
        end else if (frame_end) begin
          state_d = StIdle;
        end
      end
      StHdr: begin
        if (bus.rx_dv) begin
          dly_d = {dly_q[4:0], bus.rx_dat};
          crc_d = crc_byte(crc_q, bus.rx_dat);
          len_d = len_q + LenW'(1);
          if (len_q == LenW'(5)) begin
            if (da_ok) begin
              state_d    = StPass;
              sof_pend_d = 1'b1;
            end else begin
              state_d  = StDrop;
              inc_filt = 1'b1;
            end
          end
        end else if (frame_end) begin
          state_d = StIdle;
        end
      end
      StPass: begin
        if (bus.rx_dv) begin
          dly_d      = {dly_q[4:0], bus.rx_dat};
          crc_d      = crc_byte(crc_q, bus.rx_dat);
          len_d      = len_q + LenW'(1);
          out_vd_d   = 1'b1;
          out_dat_d  = dly_q[5];
          out_sof_d  = sof_pend_q;
          sof_pend_d = 1'b0;
          // Oversize: this byte brings len to MAX_LEN+1, close the frame as bad.
          if (len_q == LenW'(MAX_LEN)) begin
            out_eof_d = 1'b1;
            out_err_d = 1'b1;
            state_d   = StDrop;
          end
        end else if (frame_end) begin
          state_d = StFlush;
          flush_d = 1'b0;
        end
      end
      StFlush: begin
        // Stages 3..0 hold the FCS and are never emitted.
        out_vd_d   = 1'b1;
        out_sof_d  = sof_pend_q;
        sof_pend_d = 1'b0;
        if (!flush_q) begin
          out_dat_d = dly_q[5];
          flush_d   = 1'b1;
        end else begin
          out_dat_d = dly_q[4];
          out_eof_d = 1'b1;
          out_err_d = crc_bad | runt;
          inc_ok    = !crc_bad && !runt;
          inc_crc   = crc_bad;
          flush_d   = 1'b0;
          state_d   = StIdle;
        end
      end
      StDrop: begin
        if (frame_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dly_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      len_q      <= '0;
      gap_q      <= '0;
      sof_pend_q <= 1'b0;
      flush_q    <= 1'b0;
      out_dat_q  <= 8'h00;
      out_vd_q   <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_err_q  <= 1'b0;
      cnt_ok_q   <= 16'h0000;
      cnt_crc_q  <= 16'h0000;
      cnt_filt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      sof_pend_q <= sof_pend_d;
      flush_q    <= flush_d;
      out_dat_q  <= out_dat_d;
      out_vd_q   <= out_vd_d;
      out_sof_q  <= out_sof_d;
      out_eof_q  <= out_eof_d;
      out_err_q  <= out_err_d;
      if (inc_ok)   cnt_ok_q   <= sat_inc(cnt_ok_q);
      if (inc_crc)  cnt_crc_q  <= sat_inc(cnt_crc_q);
      if (inc_filt) cnt_filt_q <= sat_inc(cnt_filt_q);
    end
  end

  assign bus.out_dat = out_dat_q;
  assign bus.out_vd  = out_vd_q;
  assign bus.out_sof = out_sof_q;
  assign bus.out_eof = out_eof_q;
  assign bus.out_err = out_err_q;
  assign cnt_ok      = cnt_ok_q;
  assign cnt_crc     = cnt_crc_q;
  assign cnt_filt    = cnt_filt_q;

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: directed frames plus randomized frames, each burst run through
// a frame-level reference model that yields the expected output bytes and counter values.
module tb_eth_rx_frame_ctrl;

  localparam int unsigned MaxLen = 1518;
  localparam int unsigned MinLen = 64;
  localparam int unsigned IfgTmo = 4;
  localparam logic [47:0] OwnMac   = 48'h00_1A_2B_3C_4D_5E;
  localparam logic [47:0] OtherMac = 48'h02_00_00_00_00_99;
  localparam logic [47:0] BcastMac = 48'hFFFF_FFFF_FFFF;

  logic        clk_125m = 1'b0;
  logic        rst_n    = 1'b0;
  logic [47:0] mac_addr = OwnMac;
  logic        promisc  = 1'b0;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_crc;
  logic [15:0] cnt_filt;

  eth_rx_frame_ctrl_if bus ();

  eth_rx_frame_ctrl #(
    .MAX_LEN (MaxLen),
    .MIN_LEN (MinLen),
    .IFG_TMO (IfgTmo)
  ) dut (
    .clk_125m (clk_125m),
    .rst_n    (rst_n),
    .bus      (bus),
    .mac_addr (mac_addr),
    .promisc  (promisc),
    .cnt_ok   (cnt_ok),
    .cnt_crc  (cnt_crc),
    .cnt_filt (cnt_filt)
  );

  always #4 clk_125m = ~clk_125m;

  int          n_tests  = 0;
  int          n_fail   = 0;
  int          exp_ok   = 0;
  int          exp_crc  = 0;
  int          exp_filt = 0;
  bit          sb_on    = 1'b0;
  logic [10:0] exp_q[$];   // {sof, eof, err, dat}
  logic [7:0]  burst[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output scoreboard, sampled away from the active edge.
  always @(negedge clk_125m) begin
    if (rst_n && sb_on) begin
      if (bus.out_vd) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out",
                    {20'h0, bus.out_vd, bus.out_sof, bus.out_eof, bus.out_err, bus.out_dat}, 32'h0);
        end else begin
          check_val("out_byte", {21'h0, bus.out_sof, bus.out_eof, bus.out_err, bus.out_dat},
                    {21'h0, exp_q.pop_front()});
        end
      end else if ({bus.out_sof, bus.out_eof, bus.out_err} != 3'b000) begin
        check_val("flags_without_vd", {29'h0, bus.out_sof, bus.out_eof, bus.out_err}, 32'h0);
      end
    end
  end

  // Standard Ethernet FCS over the first n bytes (value as a 32-bit word, LSB sent first).
  function automatic logic [31:0] calc_fcs(input logic [7:0] d[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int j = 0; j < n; j++) begin
      c = c ^ {24'h0, d[j]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk_125m);
      bus.rx_dv  = 1'b0;
      bus.rx_dat = 8'h00;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk_125m);
    bus.rx_dv  = 1'b1;
    bus.rx_dat = b;
  endtask

  // n = bytes after SFD including FCS.
  task automatic build_frame(input int pre_len, input bit bad_pre, input logic [47:0] da,
                             input int n, input bit corrupt);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    logic [7:0]  mask;
    int          p;
    burst.delete();
    for (int i = 0; i < pre_len; i++) burst.push_back(8'h55);
    burst.push_back(bad_pre ? 8'h5D : 8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(da[47-8*i -: 8]);
    if (n >= 10) begin
      while (body.size() < n - 4) body.push_back(8'($urandom_range(0, 255)));
      fcs = calc_fcs(body, n - 4);
      for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
      if (corrupt) begin
        p    = int'($urandom_range(6, n - 1));
        mask = 8'h01 << $urandom_range(0, 7);
        body[p] = body[p] ^ mask;
      end
    end else begin
      while (body.size() > n) void'(body.pop_back());
      while (body.size() < n) body.push_back(8'($urandom_range(0, 255)));
    end
    foreach (body[k]) burst.push_back(body[k]);
  endtask

  // Frame-level reference: what one burst (bounded by a long idle gap) must produce.
  task automatic model_burst();
    logic [7:0]  body[$];
    logic [47:0] da;
    logic [31:0] rx_fcs;
    int          i;
    int          n;
    int          last;
    bit          bad;
    bit          runt;
    if (burst.size() == 0 || burst[0] != 8'h55) return;
    i = 0;
    while (i < burst.size() && burst[i] == 8'h55) i++;
    if (i == burst.size()) return;
    if (burst[i] != 8'hD5) begin
      exp_filt++;
      return;
    end
    for (int k = i + 1; k < burst.size(); k++) body.push_back(burst[k]);
    n = body.size();
    if (n < 6) return;
    da = {body[0], body[1], body[2], body[3], body[4], body[5]};
    if (!(promisc || da == mac_addr || da == BcastMac)) begin
      exp_filt++;
      return;
    end
    if (n > int'(MaxLen)) begin
      last = int'(MaxLen) - 6;
      for (int k = 0; k <= last; k++) exp_q.push_back({k == 0, k == last, k == last, body[k]});
      return;
    end
    rx_fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
    bad    = (rx_fcs != calc_fcs(body, n - 4));
    runt   = (n < int'(MinLen));
    last   = n - 5;
    for (int k = 0; k <= last; k++) begin
      exp_q.push_back({k == 0, k == last, (k == last) && (bad || runt), body[k]});
    end
    if (!bad && !runt) exp_ok++;
    if (bad) exp_crc++;
  endtask

  // gap_mode: 0 none, 1 random short gaps, 2 a gap of IfgTmo-1 after every 5th byte.
  task automatic send_burst(input int gap_mode);
    foreach (burst[k]) begin
      drive_byte(burst[k]);
      if (k != burst.size() - 1) begin
        if (gap_mode == 1 && $urandom_range(0, 7) == 0) begin
          drive_idle(int'($urandom_range(1, IfgTmo - 1)));
        end else if (gap_mode == 2 && (k % 5) == 4) begin
          drive_idle(int'(IfgTmo) - 1);
        end
      end
    end
  endtask

  task automatic check_stats(input string tag);
    check_val({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
    check_val({tag, "_cnt_ok"}, {16'h0, cnt_ok}, 32'(exp_ok));
    check_val({tag, "_cnt_crc"}, {16'h0, cnt_crc}, 32'(exp_crc));
    check_val({tag, "_cnt_filt"}, {16'h0, cnt_filt}, 32'(exp_filt));
  endtask

  task automatic run_frame(input string tag, input int pre_len, input bit bad_pre,
                           input logic [47:0] da, input int n, input bit corrupt,
                           input int gap_mode);
    build_frame(pre_len, bad_pre, da, n, corrupt);
    model_burst();
    send_burst(gap_mode);
    drive_idle(int'(IfgTmo) + 4 + int'($urandom_range(0, 3)));
    check_stats(tag);
  endtask

  initial begin
    logic [47:0] da;
    int          n;
    bus.rx_dv  = 1'b0;
    bus.rx_dat = 8'h00;
    repeat (3) @(negedge clk_125m);
    check_val("reset_out", {23'h0, bus.out_vd, bus.out_sof, bus.out_eof, bus.out_err,
                            bus.out_dat}, 32'h0);
    check_stats("reset");
    rst_n = 1'b1;
    sb_on = 1'b1;
    drive_idle(4);

    run_frame("good64", 7, 1'b0, OwnMac, 64, 1'b0, 0);
    run_frame("badcrc", 7, 1'b0, OwnMac, 64, 1'b1, 0);
    run_frame("filt", 7, 1'b0, OtherMac, 64, 1'b0, 0);
    promisc = 1'b1;
    run_frame("promisc", 7, 1'b0, OtherMac, 64, 1'b0, 0);
    promisc = 1'b0;
    run_frame("oversize", 7, 1'b0, BcastMac, 1600, 1'b0, 0);
    run_frame("gap3", 7, 1'b0, OwnMac, 100, 1'b0, 2);

    // A gap of IfgTmo cuts the frame after 30 bytes; the tail lands in IDLE and is dropped.
    build_frame(7, 1'b0, OwnMac, 64, 1'b0);
    while (burst.size() > 38) void'(burst.pop_back());
    model_burst();
    send_burst(0);
    drive_idle(int'(IfgTmo));
    burst.delete();
    repeat (20) burst.push_back(8'h00);
    model_burst();
    send_burst(0);
    drive_idle(int'(IfgTmo) + 6);
    check_stats("gap4");

    // Back-to-back frames with IfgTmo+2 idle cycles between them.
    build_frame(7, 1'b0, OwnMac, 70, 1'b0);
    model_burst();
    send_burst(0);
    drive_idle(int'(IfgTmo) + 2);
    build_frame(7, 1'b0, BcastMac, 64, 1'b0);
    model_burst();
    send_burst(0);
    drive_idle(int'(IfgTmo) + 6);
    check_stats("b2b");

    // Reset in the middle of a frame.
    sb_on = 1'b0;
    build_frame(7, 1'b0, OwnMac, 80, 1'b0);
    while (burst.size() > 48) void'(burst.pop_back());
    send_burst(0);
    @(negedge clk_125m);
    rst_n      = 1'b0;
    bus.rx_dv  = 1'b0;
    bus.rx_dat = 8'h00;
    @(negedge clk_125m);
    check_val("midrst_out", {23'h0, bus.out_vd, bus.out_sof, bus.out_eof, bus.out_err,
                             bus.out_dat}, 32'h0);
    exp_ok   = 0;
    exp_crc  = 0;
    exp_filt = 0;
    exp_q.delete();
    check_stats("midrst");
    drive_idle(2);
    rst_n = 1'b1;
    drive_idle(3);
    sb_on = 1'b1;
    run_frame("after_rst", 7, 1'b0, OwnMac, 64, 1'b0, 0);

    for (int it = 0; it < 40; it++) begin
      promisc = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       da = OwnMac;
        1:       da = BcastMac;
        default: da = {OtherMac[47:8], 8'($urandom_range(0, 255))};
      endcase
      case ($urandom_range(0, 9))
        0:       n = int'($urandom_range(1, 9));
        1, 2:    n = int'($urandom_range(10, MinLen - 1));
        default: n = int'($urandom_range(MinLen, 300));
      endcase
      run_frame("rand", int'($urandom_range(1, 8)), ($urandom_range(0, 9) == 0), da, n,
                ($urandom_range(0, 3) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
